// File: rtl/memaccess_stage.sv
// MEM stage: passes ALU/ecall/store results to MEM/WB in one cycle and runs
// loads through the data cache, lane-selecting and extending the returned doubleword.
module memaccess_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exmem_valid,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_aluresult,
  input  logic [DATA_W-1:0] exmem_storedata,
  input  logic              exmem_memread,
  input  logic              exmem_memwrite,
  input  logic [2:0]        exmem_funct3,
  input  logic              exmem_wbactive,
  input  logic              exmem_ecall,
  output logic              mem_stall,
  output logic              dc_req_valid,
  output logic [DATA_W-1:0] dc_req_addr,
  input  logic              dc_req_ready,
  input  logic              dc_resp_valid,
  input  logic [DATA_W-1:0] dc_resp_data,
  output logic [REG_W-1:0]  memwb_rd,
  output logic [DATA_W-1:0] memwb_aluresult,
  output logic [DATA_W-1:0] memwb_loadeddata,
  output logic              memwb_dataselect,
  output logic              memwb_wbactive,
  output logic              memwb_ready,
  output logic              memwb_ecall,
  output logic              memwb_pend_write,
  output logic [3:0]        memwb_size,
  output logic [DATA_W-1:0] memwb_value,
  output logic [DATA_W-1:0] memwb_addr
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, DRAIN, REQ, WAIT} state_t;
  state_t state, state_nxt;

  logic [REG_W-1:0]  ld_rd;
  logic [DATA_W-1:0] ld_addr;
  logic [2:0]        ld_funct3;
  logic              ld_wbactive;
  logic              ld_accept, resp_fire;

  assign ld_accept = (state == IDLE) && exmem_valid && exmem_memread;
  assign resp_fire = (state == WAIT) && dc_resp_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (ld_accept) state_nxt = memwb_pend_write ? DRAIN : REQ;
      DRAIN: state_nxt = REQ;
      REQ:   if (dc_req_ready) state_nxt = WAIT;
      WAIT:  if (dc_resp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_stall    = (state != IDLE) || ld_accept;
  assign dc_req_valid = (state == REQ);
  assign dc_req_addr  = {ld_addr[DATA_W-1:OFF_W], {OFF_W{1'b0}}};

  // Byte lane i of the result takes response lane (offset + i); lanes past the top read 0.
  logic [NB-1:0][7:0] resp_b, sel_b;
  logic [DATA_W-1:0]  sel, ext;
  assign resp_b = dc_resp_data;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    logic [OFF_W:0] src;
    assign src      = {1'b0, ld_addr[OFF_W-1:0]} + (OFF_W+1)'(i);
    assign sel_b[i] = src[OFF_W] ? 8'h00 : resp_b[src[OFF_W-1:0]];
  end
  assign sel = sel_b;

  always_comb begin
    case (ld_funct3[1:0])
      2'd0:    ext = {{(DATA_W-8){sel[7] & ~ld_funct3[2]}}, sel[7:0]};
      2'd1:    ext = {{(DATA_W-16){sel[15] & ~ld_funct3[2]}}, sel[15:0]};
      2'd2:    ext = {{(DATA_W-32){sel[31] & ~ld_funct3[2]}}, sel[31:0]};
      default: ext = sel;
    endcase
  end

  logic [DATA_W-1:0] st_mask;
  always_comb begin
    case (exmem_funct3[1:0])
      2'd0:    st_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
      2'd1:    st_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
      2'd2:    st_mask = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
      default: st_mask = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      ld_rd            <= '0;
      ld_addr          <= '0;
      ld_funct3        <= '0;
      ld_wbactive      <= 1'b0;
      memwb_rd         <= '0;
      memwb_aluresult  <= '0;
      memwb_loadeddata <= '0;
      memwb_dataselect <= 1'b0;
      memwb_wbactive   <= 1'b0;
      memwb_ready      <= 1'b0;
      memwb_ecall      <= 1'b0;
      memwb_pend_write <= 1'b0;
      memwb_size       <= '0;
      memwb_value      <= '0;
      memwb_addr       <= '0;
    end else begin
      state            <= state_nxt;
      // Control flags are single-cycle pulses; data fields hold unless rewritten.
      memwb_ready      <= 1'b0;
      memwb_wbactive   <= 1'b0;
      memwb_ecall      <= 1'b0;
      memwb_pend_write <= 1'b0;
      if (ld_accept) begin
        ld_rd       <= exmem_rd;
        ld_addr     <= exmem_aluresult;
        ld_funct3   <= exmem_funct3;
        ld_wbactive <= exmem_wbactive;
      end else if (state == IDLE && exmem_valid) begin
        memwb_rd         <= exmem_rd;
        memwb_aluresult  <= exmem_aluresult;
        memwb_dataselect <= 1'b0;
        memwb_ready      <= 1'b1;
        memwb_wbactive   <= exmem_wbactive;
        memwb_ecall      <= exmem_ecall;
        memwb_pend_write <= exmem_memwrite;
        if (exmem_memwrite) begin
          memwb_size  <= 4'd1 << exmem_funct3[1:0];
          memwb_value <= exmem_storedata & st_mask;
          memwb_addr  <= exmem_aluresult;
        end
      end
      if (resp_fire) begin
        memwb_rd         <= ld_rd;
        memwb_aluresult  <= ld_addr;
        memwb_loadeddata <= ext;
        memwb_dataselect <= 1'b1;
        memwb_ready      <= 1'b1;
        memwb_wbactive   <= ld_wbactive;
      end
    end
  end
endmodule
